fetch_insn: RTL and testbench

Instruction fetch unit that drives the instruction memory's read port and delivers instructions in order to decode over a valid/ready handshake. It owns the program counter, issues one memory read per cycle when buffer space allows, and tracks the memory's fixed 1-cycle read latency. It also absorbs decode back-pressure in a 2-entry buffer and squashes stale fetches on a redirect. It sits between `memory_insn` and the decode stage.

---
 rtl/fetch_insn_pkg.sv | 20 ++
 rtl/fetch_insn_if.sv | 39 +++
 rtl/fetch_insn_buf.sv | 50 +++++
 rtl/fetch_insn.sv | 96 +++++++++
 tb/tb_fetch_insn.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_insn_pkg.sv
// Shared constants for the instruction fetch slice: instruction memory geometry,
// reset PC, and buffer sizing for fetch_insn.
package fetch_insn_pkg;

  localparam int unsigned MEM_INSN_ADDR = 10;
  localparam int unsigned LEN_INSN_REG  = 32;
  localparam int unsigned RESET_INSN_PC = 0;

  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned OCC_W     = 3;

  // Words buffered or in flight once this cycle's pop has been taken out.
  function automatic logic [OCC_W-1:0] occ_after_pop(input logic [CNT_W-1:0] cnt,
                                                      input logic             infl,
                                                      input logic             pop);
    return OCC_W'(cnt) + OCC_W'(infl) - OCC_W'(pop);
  endfunction

endpackage

// File: rtl/fetch_insn_if.sv
// Fetch-side bus: instruction memory read port, redirect request and the
// valid/ready instruction stream towards decode.
interface fetch_insn_if import fetch_insn_pkg::*; #(
  parameter int unsigned MEM_ADDR = MEM_INSN_ADDR,
  parameter int unsigned LEN_REG  = LEN_INSN_REG
);

  logic [MEM_ADDR-1:0] mem_addr;
  logic [LEN_REG-1:0]  mem_q;
  logic                redirect_valid;
  logic [MEM_ADDR-1:0] redirect_pc;
  logic                insn_valid;
  logic                insn_ready;
  logic [LEN_REG-1:0]  insn;
  logic [MEM_ADDR-1:0] insn_pc;

  modport master (
    output mem_addr,
    input  mem_q,
    input  redirect_valid,
    input  redirect_pc,
    output insn_valid,
    input  insn_ready,
    output insn,
    output insn_pc
  );

  modport slave (
    input  mem_addr,
    output mem_q,
    output redirect_valid,
    output redirect_pc,
    input  insn_valid,
    output insn_ready,
    input  insn,
    input  insn_pc
  );

endinterface

// File: rtl/fetch_insn_buf.sv
// Two-entry synchronous FIFO holding fetched {pc, insn} words; flush empties it
// and takes priority over any push or pop in the same cycle.
module fetch_insn_buf import fetch_insn_pkg::*; #(
  parameter int unsigned W = MEM_INSN_ADDR + LEN_INSN_REG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     din,
  output logic [CNT_W-1:0] count,
  output logic [W-1:0]     head
);

  logic [W-1:0] tail_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      head   <= '0;
      tail_q <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == '0) head   <= din;
          else             tail_q <= din;
          count <= count + CNT_W'(1);
        end
        2'b01: begin
          head  <= tail_q;
          count <= count - CNT_W'(1);
        end
        // Push and pop together: count is unchanged, head advances.
        2'b11: begin
          if (count == CNT_W'(1)) begin
            head <= din;
          end else begin
            head   <= tail_q;
            tail_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_insn.sv
// Instruction fetch unit: owns the PC, issues reads to a 1-cycle-latency memory,
// buffers returned words for decode and squashes stale fetches on redirect.
// Optional FETCH_INSN_STAT_EN adds stat_fetched / stat_squashed counters.
module fetch_insn import fetch_insn_pkg::*; #(
  parameter int unsigned MEM_ADDR = MEM_INSN_ADDR,
  parameter int unsigned LEN_REG  = LEN_INSN_REG,
  parameter int unsigned RESET_PC = RESET_INSN_PC
) (
  input  logic         clk,
  input  logic         rst,
  fetch_insn_if.master bus
`ifdef FETCH_INSN_STAT_EN
  ,
  output logic [31:0]  stat_fetched,
  output logic [31:0]  stat_squashed
`endif
);

  localparam int unsigned         ENT_W  = MEM_ADDR + LEN_REG;
  localparam logic [MEM_ADDR-1:0] PC_RST = MEM_ADDR'(RESET_PC);

  logic [MEM_ADDR-1:0] pc_q;
  logic [MEM_ADDR-1:0] infl_pc_q;
  logic                infl_q;
  logic [MEM_ADDR-1:0] addr_c;
  logic                issue_c;
  logic                pop_c;
  logic                push_c;
  logic [CNT_W-1:0]    buf_count;
  logic [ENT_W-1:0]    buf_head;

  assign pop_c  = bus.insn_valid && bus.insn_ready;
  assign push_c = infl_q && !bus.redirect_valid;

  // Address mux and issue decision; a redirect always issues its target.
  always_comb begin
    addr_c  = pc_q;
    issue_c = 1'b0;
    if (rst) begin
      addr_c = PC_RST;
    end else if (bus.redirect_valid) begin
      addr_c  = bus.redirect_pc;
      issue_c = 1'b1;
    end else begin
      issue_c = occ_after_pop(buf_count, infl_q, pop_c) <= OCC_W'(1);
    end
  end

  assign bus.mem_addr = addr_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= PC_RST;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
    end else begin
      infl_q <= issue_c;
      if (issue_c) begin
        infl_pc_q <= addr_c;
        pc_q      <= addr_c + MEM_ADDR'(1);
      end
    end
  end

  fetch_insn_buf #(.W(ENT_W)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .flush (bus.redirect_valid),
    .din   ({infl_pc_q, bus.mem_q}),
    .count (buf_count),
    .head  (buf_head)
  );

  assign bus.insn_valid = buf_count != '0;
  assign bus.insn_pc    = buf_head[ENT_W-1 -: MEM_ADDR];
  assign bus.insn       = buf_head[LEN_REG-1:0];

`ifdef FETCH_INSN_STAT_EN
  // Words lost to a redirect: buffered entries not popped plus the in-flight read.
  logic [31:0] drop_c;
  assign drop_c = 32'(buf_count) - 32'(pop_c) + 32'(infl_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetched  <= '0;
      stat_squashed <= '0;
    end else begin
      if (pop_c)              stat_fetched  <= stat_fetched + 32'd1;
      if (bus.redirect_valid) stat_squashed <= stat_squashed + drop_c;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_insn.sv
// Bench for fetch_insn: 1-cycle memory model with mem[i] = 0x1000 + i and an
// in-order scoreboard of expected fetch PCs checked on every transfer.
module tb_fetch_insn;
  import fetch_insn_pkg::*;

  localparam int unsigned AW    = MEM_INSN_ADDR;
  localparam int unsigned DW    = LEN_INSN_REG;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_insn_if #(.MEM_ADDR(AW), .LEN_REG(DW)) bus ();

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) bus.mem_q <= mem[bus.mem_addr];

`ifdef FETCH_INSN_STAT_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_squashed;
`endif

  fetch_insn dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_INSN_STAT_EN
    ,
    .stat_fetched  (stat_fetched),
    .stat_squashed (stat_squashed)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;
  logic [AW-1:0] exp_q [$];

  // Scoreboard a transfer about to happen at the next edge, then advance one cycle.
  task automatic tick();
    logic [AW-1:0] exp_pc;
    logic [DW-1:0] exp_insn;
    if (bus.insn_valid === 1'b1 && bus.insn_ready === 1'b1) begin
      n_checks++;
      n_xfer++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL xfer_unexpected: got pc %0h insn %0h, expected no transfer",
                 bus.insn_pc, bus.insn);
      end else begin
        exp_pc   = exp_q.pop_front();
        exp_insn = 32'h1000 + 32'(exp_pc);
        if (bus.insn_pc !== exp_pc || bus.insn !== exp_insn) begin
          n_fail++;
          $display("FAIL xfer_order: got pc %0h insn %0h, expected pc %0h insn %0h",
                   bus.insn_pc, bus.insn, exp_pc, exp_insn);
        end
      end
    end
    n_checks++;
    if (dut.buf_count > CNT_W'(BUF_DEPTH)) begin
      n_fail++;
      $display("FAIL buf_overflow: got count %0d, expected <= %0d", dut.buf_count, BUF_DEPTH);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.insn_ready     = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = AW'(16'h55);
    tick();
    tick();
    #1;
    n_checks++;
    if (bus.insn_valid !== 1'b0 || bus.mem_addr !== AW'(0)) begin
      n_fail++;
      $display("FAIL reset_out: got valid %b addr %0h, expected valid 0 addr 0",
               bus.insn_valid, bus.mem_addr);
    end
    bus.redirect_valid = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(AW'(i));
    rst = 1'b0;
    bus.insn_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++;
      if (bus.insn_valid !== (c >= 2)) begin
        n_fail++;
        $display("FAIL stream_valid: cycle %0d got %b, expected %b", c, bus.insn_valid, (c >= 2));
      end
      if (c == 2) begin
        n_checks++;
        if (bus.insn_pc !== AW'(0) || bus.insn !== 32'h1000) begin
          n_fail++;
          $display("FAIL first_insn: got pc %0h insn %0h, expected pc 0 insn 1000",
                   bus.insn_pc, bus.insn);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    bus.insn_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (bus.insn_valid !== 1'b1 || bus.insn_pc !== AW'(4)) begin
        n_fail++;
        $display("FAIL stall_hold: cycle %0d got valid %b pc %0h, expected valid 1 pc 4",
                 c, bus.insn_valid, bus.insn_pc);
      end
      n_checks++;
      if (bus.mem_addr !== AW'(6)) begin
        n_fail++;
        $display("FAIL stall_addr: cycle %0d got %0h, expected 6", c, bus.mem_addr);
      end
      if (c >= 1) begin
        n_checks++;
        if (dut.buf_count !== CNT_W'(2) || dut.infl_q !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_full: cycle %0d got count %0d infl %b, expected count 2 infl 0",
                   c, dut.buf_count, dut.infl_q);
        end
      end
      tick();
    end
    bus.insn_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++;
      if (bus.insn_valid !== 1'b1 || bus.insn_pc !== AW'(4 + c)) begin
        n_fail++;
        $display("FAIL stall_resume: cycle %0d got valid %b pc %0h, expected valid 1 pc %0h",
                 c, bus.insn_valid, bus.insn_pc, 4 + c);
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = AW'(16'h20);
    #1;
    n_checks++;
    if (bus.mem_addr !== AW'(16'h20)) begin
      n_fail++;
      $display("FAIL redir_addr: got %0h, expected 20", bus.mem_addr);
    end
    tick();
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(AW'(16'h20 + i));
    bus.redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.insn_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_stale: got valid %b pc %0h, expected valid 0", bus.insn_valid, bus.insn_pc);
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (bus.insn_valid !== 1'b1 || bus.insn_pc !== AW'(16'h20 + c)) begin
        n_fail++;
        $display("FAIL redir_target: cycle %0d got valid %b pc %0h, expected valid 1 pc %0h",
                 c, bus.insn_valid, bus.insn_pc, 16'h20 + c);
      end
      tick();
    end
  endtask

  task automatic test_double_redirect();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = AW'(16'h30);
    tick();
    exp_q.delete();
    bus.redirect_pc = AW'(16'h40);
    #1;
    n_checks++;
    if (bus.insn_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL dbl_redir_mid: got valid %b pc %0h, expected valid 0", bus.insn_valid, bus.insn_pc);
    end
    tick();
    for (int i = 0; i < 16; i++) exp_q.push_back(AW'(16'h40 + i));
    bus.redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.insn_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL dbl_redir_stale: got valid %b pc %0h, expected valid 0", bus.insn_valid, bus.insn_pc);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (bus.insn_valid !== 1'b1 || bus.insn_pc !== AW'(16'h40 + c)) begin
        n_fail++;
        $display("FAIL dbl_redir_target: cycle %0d got valid %b pc %0h, expected valid 1 pc %0h",
                 c, bus.insn_valid, bus.insn_pc, 16'h40 + c);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] w;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = AW'(DEPTH - 1);
    tick();
    exp_q.delete();
    w = AW'(DEPTH - 1);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(w);
      w = w + AW'(1);
    end
    bus.redirect_valid = 1'b0;
    tick();
    w = AW'(DEPTH - 1);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (bus.insn_valid !== 1'b1 || bus.insn_pc !== w) begin
        n_fail++;
        $display("FAIL wrap_seq: cycle %0d got valid %b pc %0h, expected valid 1 pc %0h",
                 c, bus.insn_valid, bus.insn_pc, w);
      end
      w = w + AW'(1);
      tick();
    end
  endtask

  task automatic test_reset_mid();
    bus.insn_ready = 1'b0;
    tick();
    tick();
    tick();
    #1;
    n_checks++;
    if (dut.buf_count !== CNT_W'(2)) begin
      n_fail++;
      $display("FAIL pre_rst_full: got count %0d, expected 2", dut.buf_count);
    end
`ifdef FETCH_INSN_STAT_EN
    n_checks++;
    if (stat_fetched !== 32'(n_xfer)) begin
      n_fail++;
      $display("FAIL stat_fetched: got %0d, expected %0d", stat_fetched, n_xfer);
    end
`endif
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.mem_addr !== AW'(0)) begin
      n_fail++;
      $display("FAIL rst_addr: got %0h, expected 0", bus.mem_addr);
    end
    tick();
    n_checks++;
    if (bus.insn_valid !== 1'b0 || bus.mem_addr !== AW'(0)) begin
      n_fail++;
      $display("FAIL rst_mid_out: got valid %b addr %0h, expected valid 0 addr 0",
               bus.insn_valid, bus.mem_addr);
    end
`ifdef FETCH_INSN_STAT_EN
    n_checks++;
    if (stat_fetched !== 32'd0 || stat_squashed !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_stats: got fetched %0d squashed %0d, expected 0 0",
               stat_fetched, stat_squashed);
    end
`endif
    tick();
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(AW'(i));
    rst = 1'b0;
    bus.insn_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++;
      if (bus.insn_valid !== (c >= 2) || (c >= 2 && bus.insn_pc !== AW'(c - 2))) begin
        n_fail++;
        $display("FAIL rst_restart: cycle %0d got valid %b pc %0h, expected valid %b pc %0h",
                 c, bus.insn_valid, bus.insn_pc, (c >= 2), (c >= 2) ? c - 2 : 0);
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000 + 32'(i);
    rst                = 1'b1;
    bus.insn_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_double_redirect();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
